// File: rtl/demux1_8_deser.sv
// demux1_8_deser: serial-to-parallel receive end for the 8:1 select path.
// Each accepted bit is steered into one slot of an 8-bit assembly register,
// which makes this a 1:8 demultiplexer driven by a 3-bit slot counter. Every
// completed byte is moved into a holding register that the consumer drains
// through a valid/ready handshake. A byte that completes while the holding
// register is still occupied is dropped, and a sticky overrun flag records it.
//
// Parameters:
//   MSB_FIRST  0: first bit of a frame lands in o[0]; 1: it lands in o[7]
// Ports:
//   clk      in   clock, rising edge
//   rst      in   asynchronous active-high reset
//   i        in   serial data bit
//   i_valid  in   i is accepted this cycle (no input backpressure)
//   sync     in   frame restart; the bit accepted with it becomes bit 0
//   s        out  slot counter (the slot the next accepted bit writes)
//   o        out  holding register (last completed word)
//   o_valid  out  o holds an unconsumed word
//   o_ready  in   consumer takes o when o_valid && o_ready
//   overrun  out  sticky: a completed word was dropped
//   clr_ovr  in   clears overrun (a new overrun in the same cycle wins)
module demux1_8_deser #(
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i,
  input  logic       i_valid,
  input  logic       sync,
  output logic [2:0] s,
  output logic [7:0] o,
  output logic       o_valid,
  input  logic       o_ready,
  output logic       overrun,
  input  logic       clr_ovr
);

  logic [2:0] cnt_q, cnt_d;
  logic [7:0] asm_q, asm_d;
  logic [7:0] o_q, o_d;
  logic       o_valid_q, o_valid_d;
  logic       ovr_q, ovr_d;

  logic [2:0] idx;
  logic [2:0] idx_first;
  logic [7:0] word;
  logic       complete;
  logic       load;
  logic       drop;

  always_comb begin
    idx       = MSB_FIRST ? (3'd7 - cnt_q) : cnt_q;
    idx_first = MSB_FIRST ? 3'd7 : 3'd0;

    // Assembly register with the current bit already inserted.
    word      = asm_q;
    word[idx] = i;

    // sync outranks completion, even at cnt = 7.
    complete = i_valid & ~sync & (cnt_q == 3'd7);
    // A full holding register that is drained this cycle can accept the new word.
    load     = complete & (~o_valid_q | o_ready);
    drop     = complete & ~load;
  end

  always_comb begin
    cnt_d = cnt_q;
    asm_d = asm_q;
    if (sync) begin
      asm_d = 8'h00;
      if (i_valid) begin
        asm_d[idx_first] = i;
        cnt_d            = 3'd1;
      end else begin
        cnt_d = 3'd0;
      end
    end else if (i_valid) begin
      cnt_d = cnt_q + 3'd1;
      asm_d = complete ? 8'h00 : word;
    end
  end

  always_comb begin
    o_d       = o_q;
    o_valid_d = o_valid_q;
    if (load) begin
      o_d       = word;
      o_valid_d = 1'b1;
    end else if (o_valid_q && o_ready) begin
      o_valid_d = 1'b0;
    end
  end

  always_comb begin
    ovr_d = ovr_q;
    if (drop) begin
      ovr_d = 1'b1;
    end else if (clr_ovr) begin
      ovr_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= 3'd0;
      asm_q     <= 8'h00;
      o_q       <= 8'h00;
      o_valid_q <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      asm_q     <= asm_d;
      o_q       <= o_d;
      o_valid_q <= o_valid_d;
      ovr_q     <= ovr_d;
    end
  end

  assign s       = cnt_q;
  assign o       = o_q;
  assign o_valid = o_valid_q;
  assign overrun = ovr_q;

endmodule
